// File: rtl/intcalc_seq_pkg.sv
// Shared types for the bexkat1 integer unit: function codes, controller states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bexkat1Def;

  // Integer unit function select, as decoded by the execute stage.
  typedef enum logic [3:0] {
    INT_MUL   = 4'h0,
    INT_DIV   = 4'h1,
    INT_MOD   = 4'h2,
    INT_MULU  = 4'h3,
    INT_DIVU  = 4'h4,
    INT_MODU  = 4'h5,
    INT_MULX  = 4'h6,
    INT_MULUX = 4'h7,
    INT_EXT   = 4'h8,
    INT_EXTB  = 4'h9,
    INT_COM   = 4'ha,
    INT_NEG   = 4'hb
  } intfunc_t;

  // Sequencing controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } intcalc_state_t;

  // True for the four funcs that go through the iterative divider.
  function automatic logic is_divfunc(intfunc_t f);
    return (f == INT_DIV) || (f == INT_MOD) || (f == INT_DIVU) || (f == INT_MODU);
  endfunction

  // True for the signed divide funcs (operands read as two's complement).
  function automatic logic is_signed_div(intfunc_t f);
    return (f == INT_DIV) || (f == INT_MOD);
  endfunction

  // True when the remainder, rather than the quotient, is the result.
  function automatic logic is_mod_func(intfunc_t f);
    return (f == INT_MOD) || (f == INT_MODU);
  endfunction

endpackage

// File: rtl/intcalc_seq_if.sv
// Operation/result handshake bundle between execute stage and the integer controller.
// Latency: n/a (wires only).
// Backpressure: in_ready stalls the producer; out_ready stalls the result holder.
interface intcalc_seq_if #(
  parameter int WIDTH = 32
);
  import bexkat1Def::*;

  logic             in_valid;
  logic             in_ready;
  intfunc_t         func;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             divzero;

  // Producer/consumer side (execute stage + writeback).
  modport master (
    output in_valid, func, in1, in2, out_ready,
    input  in_ready, out_valid, out, divzero
  );

  // Controller side.
  modport slave (
    input  in_valid, func, in1, in2, out_ready,
    output in_ready, out_valid, out, divzero
  );

endinterface

// File: rtl/intcalc_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: start sampled at edge N; iterations in cycles N+1..N+WIDTH; done pulses in N+WIDTH+1.
// Backpressure: none; a new start while busy restarts the divider (the controller never does this).
module intdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvsr};
  end

  // Iteration register: load on start, then one restoring step per cycle until the count runs out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo  <= dividend;
        dvsr <= divisor;
        rem  <= '0;
        cnt  <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        // diff[WIDTH] set means the trial went negative: keep (restore) the shifted remainder.
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign last      = busy && (cnt == '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/intcalc_seq.sv
// bexkat1 integer unit controller: registered single-cycle ops, iterative DIV/MOD (INTCALC_DIVZERO_EN gates the divide-by-zero shortcut).
// Latency: non-divide result valid at N+1, divide at N+WIDTH+2 after accept at N.
// Backpressure: result held in DONE until out_ready; new ops accepted only in IDLE or DONE with out_ready.
module intcalc_seq
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  intcalc_seq_if.slave bus
);

  intcalc_state_t state, state_nxt;

  logic [WIDTH-1:0] out_q, out_nxt;
  logic             qneg_q, qneg_nxt;
  logic             rneg_q, rneg_nxt;
  logic             mod_q, mod_nxt;
`ifdef INTCALC_DIVZERO_EN
  logic             dz_q, dz_nxt;
`endif

  logic             in_ready_c;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  logic             div_start;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             a_neg;
  logic             b_neg;
  logic             div_busy;
  logic             div_last;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  intdiv_iter #(.WIDTH(WIDTH)) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (div_start),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .busy      (div_busy),
    .last      (div_last),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign in_ready_c = !div_busy &&
                      ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_c;

  // Single-cycle functions; products formed at double width so the upper half is available.
  always_comb begin
    prod_s  = {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1} * {{WIDTH{bus.in2[WIDTH-1]}}, bus.in2};
    prod_u  = {{WIDTH{1'b0}}, bus.in1} * {{WIDTH{1'b0}}, bus.in2};
    alu_res = '0;
    case (bus.func)
      INT_MUL:   alu_res = prod_s[WIDTH-1:0];
      INT_MULU:  alu_res = prod_u[WIDTH-1:0];
      INT_MULX:  alu_res = prod_s[2*WIDTH-1:WIDTH];
      INT_MULUX: alu_res = prod_u[2*WIDTH-1:WIDTH];
      INT_EXT:   alu_res = {{(WIDTH-16){bus.in2[15]}}, bus.in2[15:0]};
      INT_EXTB:  alu_res = {{(WIDTH-8){bus.in2[7]}}, bus.in2[7:0]};
      INT_COM:   alu_res = ~bus.in2;
      INT_NEG:   alu_res = -bus.in2;
      default:   alu_res = '0;
    endcase
  end

  // Operand magnitudes for the divider; negating MIN yields 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    a_neg   = is_signed_div(bus.func) && bus.in1[WIDTH-1];
    b_neg   = is_signed_div(bus.func) && bus.in2[WIDTH-1];
    dvd_mag = a_neg ? -bus.in1 : bus.in1;
    dvs_mag = b_neg ? -bus.in2 : bus.in2;
  end

  // Re-apply signs: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    quo_s = qneg_q ? -div_quo : div_quo;
    rem_s = rneg_q ? -div_rem : div_rem;
  end

  // Next-state and result selection.
  always_comb begin
    state_nxt = state;
    out_nxt   = out_q;
    qneg_nxt  = qneg_q;
    rneg_nxt  = rneg_q;
    mod_nxt   = mod_q;
    div_start = 1'b0;
`ifdef INTCALC_DIVZERO_EN
    dz_nxt    = dz_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef INTCALC_DIVZERO_EN
          dz_nxt = 1'b0;
`endif
          if (is_divfunc(bus.func)) begin
`ifdef INTCALC_DIVZERO_EN
            if (bus.in2 == '0) begin
              out_nxt   = '0;
              dz_nxt    = 1'b1;
              state_nxt = DONE;
            end else
`endif
            begin
              div_start = 1'b1;
              qneg_nxt  = a_neg ^ b_neg;
              rneg_nxt  = a_neg;
              mod_nxt   = is_mod_func(bus.func);
              state_nxt = DIV;
            end
          end else begin
            out_nxt   = alu_res;
            state_nxt = DONE;
          end
        end else if ((state == DONE) && bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      DIV: begin
        if (div_last) state_nxt = FIX;
      end
      FIX: begin
        if (div_done) begin
          out_nxt   = mod_q ? rem_s : quo_s;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      out_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      mod_q  <= 1'b0;
`ifdef INTCALC_DIVZERO_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      out_q  <= out_nxt;
      qneg_q <= qneg_nxt;
      rneg_q <= rneg_nxt;
      mod_q  <= mod_nxt;
`ifdef INTCALC_DIVZERO_EN
      dz_q   <= dz_nxt;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
`ifdef INTCALC_DIVZERO_EN
  assign bus.divzero   = dz_q;
`else
  assign bus.divzero   = 1'b0;
`endif

endmodule

// File: tb/tb_intcalc_seq.sv
// Directed bench for intcalc_seq: vector table plus hold, back-to-back and reset-abort sequences.
// Latency: checks N+1 for single-cycle ops and N+34 for divides (WIDTH=32).
// Backpressure: exercises out_ready low in DONE and same-cycle re-accept.
module tb_intcalc_seq;
  import bexkat1Def::*;

  localparam int W = 32;
`ifdef INTCALC_DIVZERO_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intcalc_seq_if #(.WIDTH(W)) bus ();
  intcalc_seq #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    intfunc_t    f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input intfunc_t f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] q, input logic dz,
                              input int lat);
    vec_t v;
    v.name = n; v.f = f; v.a = a; v.b = b; v.q = q; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  // Issue one op with out_ready high; operands are scrambled right after accept.
  task automatic do_op(input intfunc_t f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic d, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.func      = f;
    bus.in1       = a;
    bus.in2       = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in1      = ~a;
    bus.in2      = a ^ b ^ 32'h5a5a_1234;
    bus.func     = INT_NEG;
    lat = 0;
    r   = 'x;
    d   = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        r   = bus.out;
        d   = bus.divzero;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        d;
    int          lat;
    int          seen;

    // Vector table
    vecs.push_back(mk("mul_7_m3",     INT_MUL,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1));
    vecs.push_back(mk("mulux_max_2",  INT_MULUX, 32'hFFFF_FFFF, 32'd2,        32'd1,        1'b0, 1));
    vecs.push_back(mk("mulu_lo",      INT_MULU,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 1));
    vecs.push_back(mk("mulx_m1_2",    INT_MULX,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(mk("mulx_2p32",    INT_MULX,  32'h4000_0000, 32'd4,        32'd1,        1'b0, 1));
    vecs.push_back(mk("ext_neg",      INT_EXT,   32'h1234,     32'h0000_8001, 32'hFFFF_8001, 1'b0, 1));
    vecs.push_back(mk("ext_pos",      INT_EXT,   32'h0,        32'h1234_7FFF, 32'h0000_7FFF, 1'b0, 1));
    vecs.push_back(mk("extb_neg",     INT_EXTB,  32'h0,        32'h0000_0180, 32'hFFFF_FF80, 1'b0, 1));
    vecs.push_back(mk("com",          INT_COM,   32'h0,        32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1));
    vecs.push_back(mk("neg_5",        INT_NEG,   32'h0,        32'd5,        32'hFFFF_FFFB, 1'b0, 1));
    vecs.push_back(mk("unknown",      intfunc_t'(4'hF), 32'd3, 32'd4,        32'd0,        1'b0, 1));
    vecs.push_back(mk("div_m7_2",     INT_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 34));
    vecs.push_back(mk("mod_m7_2",     INT_MOD,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 34));
    vecs.push_back(mk("divu_100_7",   INT_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 34));
    vecs.push_back(mk("modu_100_7",   INT_MODU,  32'd100,      32'd7,        32'd2,        1'b0, 34));
    vecs.push_back(mk("div_7_m2",     INT_DIV,   32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34));
    vecs.push_back(mk("mod_7_m2",     INT_MOD,   32'd7,        32'hFFFF_FFFE, 32'd1,        1'b0, 34));
    vecs.push_back(mk("div_m100_m7",  INT_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,       1'b0, 34));
    vecs.push_back(mk("mod_m100_m7",  INT_MOD,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 34));
    vecs.push_back(mk("div_min_m1",   INT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34));
    vecs.push_back(mk("mod_min_m1",   INT_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0, 34));
    vecs.push_back(mk("divu_max_1",   INT_DIVU,  32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1'b0, 34));
`ifdef INTCALC_DIVZERO_EN
    vecs.push_back(mk("divu_5_0",     INT_DIVU,  32'd5,        32'd0,        32'd0,        1'b1, DZ_LAT));
    vecs.push_back(mk("modu_5_0",     INT_MODU,  32'd5,        32'd0,        32'd0,        1'b1, DZ_LAT));
    vecs.push_back(mk("div_m5_0",     INT_DIV,   32'hFFFF_FFFB, 32'd0,        32'd0,        1'b1, DZ_LAT));
    vecs.push_back(mk("mod_m5_0",     INT_MOD,   32'hFFFF_FFFB, 32'd0,        32'd0,        1'b1, DZ_LAT));
`else
    vecs.push_back(mk("divu_5_0",     INT_DIVU,  32'd5,        32'd0,        32'hFFFF_FFFF, 1'b0, DZ_LAT));
    vecs.push_back(mk("modu_5_0",     INT_MODU,  32'd5,        32'd0,        32'd5,        1'b0, DZ_LAT));
    vecs.push_back(mk("div_m5_0",     INT_DIV,   32'hFFFF_FFFB, 32'd0,        32'd1,        1'b0, DZ_LAT));
    vecs.push_back(mk("mod_m5_0",     INT_MOD,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1'b0, DZ_LAT));
    vecs.push_back(mk("div_5_0",      INT_DIV,   32'd5,        32'd0,        32'hFFFF_FFFF, 1'b0, DZ_LAT));
`endif
    // Sentinel after a zero-divisor op: ensures divzero clears on the next op.
    vecs.push_back(mk("after_dz",     INT_DIVU,  32'd9,        32'd3,        32'd3,        1'b0, 34));

    // Reset
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.func      = INT_MUL;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out",       bus.out,                32'd0);
    chk("rst_divzero",   {31'b0, bus.divzero},   32'd0);
    chk("rst_state",     32'(dut.state),         32'(IDLE));

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, r, d, lat);
      chk({vecs[i].name, "_out"}, r, vecs[i].q);
      chk({vecs[i].name, "_dz"},  {31'b0, d}, {31'b0, vecs[i].dz});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Hold in DONE with out_ready low; busy-time in_valid must be ignored
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.func      = INT_MUL;
    bus.in1       = 32'd3;
    bus.in2       = 32'd4;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.func = INT_NEG;
    bus.in2  = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid",    {31'b0, bus.out_valid}, 32'd1);
      chk("hold_out",      bus.out,                32'd12);
      chk("hold_in_ready", {31'b0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    bus.func      = INT_COM;
    bus.in1       = 32'h1111_1111;
    bus.in2       = 32'd0;
    #1;
    chk("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("b2b_out",   bus.out,                32'hFFFF_FFFF);

    // Back-to-back MULs at full throughput
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func     = INT_MUL;
    bus.in1      = 32'd2;
    bus.in2      = 32'd3;
    @(negedge clk);
    chk("tp0_out", bus.out, 32'd6);
    chk("tp0_rdy", {31'b0, bus.in_ready}, 32'd1);
    bus.in1 = 32'd4;
    bus.in2 = 32'd5;
    @(negedge clk);
    chk("tp1_out", bus.out, 32'd20);
    bus.in1 = 32'd6;
    bus.in2 = 32'd7;
    @(negedge clk);
    chk("tp2_out",   bus.out, 32'd42);
    chk("tp2_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("tp_idle_valid", {31'b0, bus.out_valid}, 32'd0);

    // Reset in the middle of a divide
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func     = INT_DIVU;
    bus.in1      = 32'd1000;
    bus.in2      = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid",    {31'b0, bus.out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, bus.in_ready},  32'd1);
    chk("abort_state",    32'(dut.state),         32'(IDLE));
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    do_op(INT_DIVU, 32'd9, 32'd3, r, d, lat);
    chk("post_abort_out", r, 32'd3);
    chk("post_abort_lat", 32'(lat), 32'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intcalc_seq.md
# intcalc_seq

Multi-cycle controller for the bexkat1 integer unit. It accepts one operation at a time over a valid/ready handshake and returns one registered result. Single-cycle functions go through a registered path. DIV/MOD/DIVU/MODU are sequenced through an iterative restoring divider instead of a combinational one, which removes the divide from the execute-stage critical path. It sits between the bexkat1 execute stage and writeback.

## Interface
- WIDTH, 32, operand and result width.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  controller can accept an operation this cycle.
- func  in  intfunc_t  operation select (INT_MUL … INT_NEG).
- in1  in  WIDTH  operand 1; read as signed or unsigned according to func.
- in2  in  WIDTH  operand 2, the divisor/multiplier; EXT/EXTB/COM/NEG use only this operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result.
- divzero  out  1  divide-by-zero flag, qualified by out_valid.

## Operation
- States: IDLE, DIV, FIX, DONE.
- Reset values: state IDLE, out_valid 0, out 0, divzero 0, in_ready 1.
- An operation is accepted when in_valid && in_ready. in_ready is high in IDLE, and in DONE when out_ready is also high.
- Non-divide funcs (MUL, MULU, MULX, MULUX, EXT, EXTB, COM, NEG):
  - The result is computed and registered in the accept cycle. Next state is DONE.
  - MULX/MULUX return the upper WIDTH bits of the 2·WIDTH product.
  - Unknown func returns 0.
- Divide funcs on accept:
  - Latch the operand magnitudes, taking absolute values for the signed DIV/MOD; |MIN| is 2^(WIDTH-1) unsigned.
  - Latch the quotient and remainder sign flags.
  - Clear the partial remainder. Load the iteration counter with WIDTH-1. Enter DIV.
- DIV: one quotient bit per cycle, MSB first (shift, trial subtract, restore). Leave to FIX when the counter reaches 0.
- FIX:
  - Apply signs. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Select quotient or remainder into out. Enter DONE.
- Signed MIN / -1 gives quotient MIN and remainder 0, with no flag.
- DONE: out_valid = 1, and out/divzero are held stable until out_ready.
  - out_ready && in_valid: accept the new operation in the same cycle (back-to-back).
  - out_ready && !in_valid: go to IDLE.
- rst_i in any state aborts the operation: next cycle is IDLE with out_valid 0. No partial result is ever presented.
- in_valid while busy (DIV/FIX, or DONE without out_ready) is ignored; operands are not sampled.

## Timing
- Accept at cycle N.
- Non-divide: out_valid in cycle N+1.
- Divide: DIV during N+1 … N+WIDTH, FIX at N+WIDTH+1, out_valid at N+WIDTH+2 (34 for WIDTH=32).
- Throughput: one non-divide op per cycle while out_ready is held high.
- Operands are sampled only in the accept cycle; later changes on in1/in2/func have no effect.

## Configuration
- INTCALC_DIVZERO_EN defined:
  - A divide func with in2 == 0 skips DIV/FIX and goes straight to DONE at cycle N+1.
  - out = 0, divzero = 1.
- INTCALC_DIVZERO_EN undefined:
  - Divide-by-zero runs the full iteration. Unsigned quotient is all ones; remainder equals the dividend.
  - Signed quotient is -1 for a non-negative dividend and +1 for a negative dividend; remainder equals the dividend.
  - divzero is tied to 0.

## Structure
- bexkat1Def package: existing intfunc_t; add intcalc_state_t (IDLE, DIV, FIX, DONE) and the helper function is_divfunc(intfunc_t).
- Sub-module intdiv_iter:
  - Unsigned restoring divider: start, magnitudes in, busy/done, quotient/remainder out.
  - intcalc_seq owns the handshake, sign handling, non-divide path and divzero.

## Test plan
- Reset, then MUL 7 × -3 → out 0xFFFFFFEB at cycle N+1; then MULUX 0xFFFFFFFF × 2 → out 1.
- DIV -7 / 2 → out -3 at N+34; MOD -7 / 2 → -1; DIVU 100 / 7 → 14; MODU 100 / 7 → 2.
- DIV 0x80000000 / -1 → 0x80000000; MOD → 0, divzero 0.
- DIVU 5 / 0:
  - With macro: out 0, divzero 1 at N+1.
  - Without macro: out 0xFFFFFFFF at N+34; MODU 5 / 0 → 5.
- out_ready low for 5 cycles in DONE → out held constant; in_valid ignored. Raise out_ready with in_valid and COM 0 → the next op is accepted the same cycle and out = 0xFFFFFFFF one cycle later.
- rst_i asserted at cycle N+10 of a DIVU → out_valid stays 0, state IDLE, in_ready 1 the next cycle; a fresh DIVU 9 / 3 → 3.
